// File: rtl/mul_iter32.sv
// Multi-cycle 32x32 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// It works on operand magnitudes and fixes the sign of the 64-bit product in one cycle at the end.

module add32 (
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        c_in,
   output logic [31:0] s,
   output logic        c31
);
   logic [32:0] c;
   assign c[0] = c_in;
   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end
   assign c31 = c[32];
endmodule

module mul_iter32 #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [2*XLEN-1:0]   product;
   logic [XLEN-1:0]     mcand;
   logic [1:0]          op_q;
   logic                neg;

   logic                a_sgn, b_sgn;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN-1:0]     sum;
   logic                cout;
   logic [2*XLEN-1:0]   fixed;

   // MULH treats both operands as signed, MULHSU only rs1; MUL/MULHU are unsigned.
   always_comb begin
      a_sgn = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
      b_sgn = (op == 2'b01) && b[XLEN-1];
      a_mag = a_sgn ? (~a + 1'b1) : a;
      b_mag = b_sgn ? (~b + 1'b1) : b;
      fixed = neg ? (~product + 1'b1) : product;
   end

   add32 u_add (
      .x    (product[2*XLEN-1:XLEN]),
      .y    (mcand),
      .c_in (1'b0),
      .s    (sum),
      .c31  (cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         product <= '0;
         mcand   <= '0;
         op_q    <= 2'b00;
         neg     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_q    <= op;
               mcand   <= a_mag;
               neg     <= a_sgn ^ b_sgn;
               product <= {{XLEN{1'b0}}, b_mag};
               cnt     <= '0;
               busy    <= 1'b1;
               state   <= RUN;
            end
            RUN: begin
               product <= product[0] ? {cout, sum, product[XLEN-1:1]}
                                     : {1'b0, product[2*XLEN-1:1]};
               cnt     <= cnt + 1'b1;
               if (cnt == CNT_W'(XLEN-1)) state <= FIX;
            end
            FIX: begin
               product <= fixed;
               result  <= (op_q == 2'b00) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
               done    <= 1'b1;
               state   <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_iter32.sv
// Directed bench for mul_iter32: latency, product halves, busy-ignore and mid-run reset.

module tb_mul_iter32;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] result;
   int          checks = 0, errors = 0;
   int          k;

   localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

   mul_iter32 dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns number of negedges waited until done is seen (max+1 on timeout).
   task automatic wait_done(input int max, output int n);
      n = max + 1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (done) begin n = i; break; end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
      int n;
      start_op(o, x, y);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(40, n);
      chk({tag, "_lat"}, 32'(n), 32'd33);
      chk({tag, "_res"}, result, exp);
      @(negedge clk);
      chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "_hold"}, result, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_state", {30'd0, busy, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      rst = 1'b0;

      run_op("mul_3x5",      MUL,    32'd3,        32'd5,        32'h0000000F);
      run_op("mulhu_ff",     MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_op("mul_ff",       MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      run_op("mulh_min",     MULH,   32'h80000000, 32'h80000000, 32'h40000000);
      run_op("mul_neg7x3",   MUL,    32'hFFFFFFF9, 32'd3,        32'hFFFFFFEB);
      run_op("mulhsu_m1",    MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op("mulh_m1",      MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      run_op("mulh_neg7x3",  MULH,   32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF);
      run_op("mul_zero",     MUL,    32'd0,        32'h12345678, 32'h00000000);

      // A start pulse while busy is ignored and later operand changes have no effect.
      start_op(MUL, 32'd6, 32'd7);
      repeat (3) @(negedge clk);
      op = MULHU; a = 32'd2; b = 32'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(40, k);
      chk("busy_ign_lat", 32'(k + 4), 32'd33);
      chk("busy_ign_res", result, 32'h0000002A);
      wait_done(45, k);
      chk("busy_ign_single", 32'(k), 32'd46);

      // Reset in the middle of RUN aborts immediately and suppresses done.
      start_op(MUL, 32'd100, 32'd100);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_state", {30'd0, busy, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_done(40, k);
      chk("midrst_no_done", 32'(k), 32'd41);
      run_op("after_rst", MUL, 32'd100, 32'd100, 32'h00002710);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
